alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/ovf_sat_counter.sv | 20 ++
 rtl/alu_issue_stage.sv | 120 ++++++++++++
 tb/tb_alu_issue_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, ALU opcodes, and issue-stage FSM state.
// ALU opcodes are enumerated from zero so a cleared register decodes as ALU_SLL.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } issue_state_t;

endpackage

// File: rtl/ovf_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// One-cycle update; never stalls, and only RST brings it back to zero.
module ovf_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-register ALU issue stage: S1 feeds the external ALU, S2 captures its result; 2-cycle latency, 1 op/cycle.
// Valid/ready backpressure from out_ready propagates to in_ready; an overflow with trap_en parks S1 until trap_ack.
module alu_issue_stage
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  word_t            in_rdat1,
    input  word_t            in_rdat2,
    input  word_t            in_instr,
    input  aluop_t           in_aluop,
    input  logic             in_alusrc,
    output logic             in_ready,
    output word_t            alu_rdat1,
    output word_t            alu_rdat2,
    output word_t            alu_instr,
    output aluop_t           alu_aluop,
    output logic             alu_alusrc,
    input  word_t            alu_out,
    input  logic             alu_neg,
    input  logic             alu_over,
    input  logic             alu_zero,
    output logic             out_valid,
    output word_t            out_result,
    output logic             out_neg,
    output logic             out_over,
    output logic             out_zero,
    output word_t            out_instr,
    output logic             out_trap,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             trap_en,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] ovf_count
);

    issue_state_t state;
    logic         s1_valid;
    logic         s2_valid;
    logic         running;
    logic         s1_adv;
    logic         accept;

    assign running   = (state == RUN);
    assign s1_adv    = s1_valid & running & (~s2_valid | out_ready);
    assign in_ready  = running & (~s1_valid | s1_adv);
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    // alu_* and out_* ports are the pipeline flops themselves.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid   <= 1'b0;
            alu_rdat1  <= '0;
            alu_rdat2  <= '0;
            alu_instr  <= '0;
            alu_aluop  <= ALU_SLL;
            alu_alusrc <= 1'b0;
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_neg    <= 1'b0;
            out_over   <= 1'b0;
            out_zero   <= 1'b0;
            out_instr  <= '0;
            out_trap   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid   <= 1'b1;
                alu_rdat1  <= in_rdat1;
                alu_rdat2  <= in_rdat2;
                alu_instr  <= in_instr;
                alu_aluop  <= in_aluop;
                alu_alusrc <= in_alusrc;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid   <= 1'b1;
                out_result <= alu_out;
                out_neg    <= alu_neg;
                out_over   <= alu_over;
                out_zero   <= alu_zero;
                out_instr  <= alu_instr;
                out_trap   <= alu_over & trap_en;
            end else if (out_ready && s2_valid) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // trap_ack only matters while parked in TRAP.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            state <= RUN;
        end else if (state == RUN) begin
            if (s1_adv && alu_over && trap_en) begin
                state <= TRAP;
            end
        end else if (trap_ack) begin
            state <= RUN;
        end
    end

    ovf_sat_counter #(
        .CNT_W (CNT_W)
    ) u_ovf_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (s1_adv & alu_over & ~flush),
        .count (ovf_count)
    );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios plus randomized traffic.
module tb_alu_issue_stage;
    import cpu_types_pkg::*;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RST;
    logic             in_valid;
    word_t            in_rdat1;
    word_t            in_rdat2;
    word_t            in_instr;
    aluop_t           in_aluop;
    logic             in_alusrc;
    logic             in_ready;
    word_t            alu_rdat1;
    word_t            alu_rdat2;
    word_t            alu_instr;
    aluop_t           alu_aluop;
    logic             alu_alusrc;
    word_t            alu_out;
    logic             alu_neg;
    logic             alu_over;
    logic             alu_zero;
    logic             out_valid;
    word_t            out_result;
    logic             out_neg;
    logic             out_over;
    logic             out_zero;
    word_t            out_instr;
    logic             out_trap;
    logic             out_ready;
    logic             flush;
    logic             trap_en;
    logic             trap_ack;
    logic [CNT_W-1:0] ovf_count;

    typedef struct {
        word_t res;
        logic  neg;
        logic  over;
        logic  zero;
        word_t instr;
        logic  trap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   nchecks = 0;
    int   nerr    = 0;
    int   mdl_cnt = 0;

    alu_issue_stage #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_rdat1(in_rdat1), .in_rdat2(in_rdat2),
        .in_instr(in_instr), .in_aluop(in_aluop), .in_alusrc(in_alusrc),
        .in_ready(in_ready),
        .alu_rdat1(alu_rdat1), .alu_rdat2(alu_rdat2), .alu_instr(alu_instr),
        .alu_aluop(alu_aluop), .alu_alusrc(alu_alusrc),
        .alu_out(alu_out), .alu_neg(alu_neg), .alu_over(alu_over), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_result(out_result), .out_neg(out_neg),
        .out_over(out_over), .out_zero(out_zero), .out_instr(out_instr),
        .out_trap(out_trap), .out_ready(out_ready),
        .flush(flush), .trap_en(trap_en), .trap_ack(trap_ack),
        .ovf_count(ovf_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU arithmetic; returns {overflow, result}.
    function automatic logic [32:0] ref_alu(input aluop_t op, input word_t a, input word_t b_reg,
                                            input word_t instr, input logic src);
        word_t b;
        word_t r;
        logic  ov;
        b  = src ? {{16{instr[15]}}, instr[15:0]} : b_reg;
        r  = '0;
        ov = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD: begin
                r  = a + b;
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            ALU_SUB: begin
                r  = a - b;
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default:  r = '0;
        endcase
        return {ov, r};
    endfunction

    logic [32:0] alu_r;
    always_comb begin
        alu_r = ref_alu(alu_aluop, alu_rdat1, alu_rdat2, alu_instr, alu_alusrc);
    end
    assign alu_out  = alu_r[31:0];
    assign alu_over = alu_r[32];
    assign alu_neg  = alu_r[31];
    assign alu_zero = (alu_r[31:0] == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nchecks++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t mk_exp();
        exp_t        e;
        logic [32:0] r;
        r       = ref_alu(in_aluop, in_rdat1, in_rdat2, in_instr, in_alusrc);
        e.res   = r[31:0];
        e.over  = r[32];
        e.neg   = r[31];
        e.zero  = (r[31:0] == 32'd0);
        e.instr = in_instr;
        e.trap  = r[32] & trap_en;
        return e;
    endfunction

    // Monitor: every delivered result must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL unexpected_output: got result 0x%0h instr 0x%0h, expected none",
                         out_result, out_instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_result", out_result, mon_e.res);
                chk("out_neg", 32'(out_neg), 32'(mon_e.neg));
                chk("out_over", 32'(out_over), 32'(mon_e.over));
                chk("out_zero", 32'(out_zero), 32'(mon_e.zero));
                chk("out_instr", out_instr, mon_e.instr);
                chk("out_trap", 32'(out_trap), 32'(mon_e.trap));
                if (mon_e.over && mdl_cnt < CNT_MAX) mdl_cnt++;
            end
        end
        if (RST || flush) exp_q.delete();
        if (RST) mdl_cnt = 0;
    end

    // One clock: sample the handshake mid-cycle, record accepted ops after the edge.
    task automatic tick(output bit acc);
        bit a;
        @(negedge CLK);
        a = in_valid && in_ready && !flush && !RST;
        @(posedge CLK);
        #1;
        if (a) exp_q.push_back(mk_exp());
        acc = a;
    endtask

    task automatic step();
        bit d;
        tick(d);
    endtask

    task automatic drive(input aluop_t op, input word_t a, input word_t b);
        in_valid  = 1'b1;
        in_aluop  = op;
        in_rdat1  = a;
        in_rdat2  = b;
        in_instr  = $urandom;
        in_alusrc = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        bit a;
        int n;
        n = 0;
        do begin
            tick(a);
            n++;
        end while (!a && n < 50);
        chk(name, 32'(a), 32'd1);
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        trap_ack = 1'b0;
        step();
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic rand_phase(input int n, input bit ten);
        trap_en = ten;
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_aluop  = aluop_t'(4'($urandom_range(0, 9)));
            in_rdat1  = $urandom;
            in_rdat2  = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            in_instr  = $urandom;
            in_alusrc = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            trap_ack  = ($urandom_range(0, 3) == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        trap_ack  = 1'b1;
        repeat (6) step();
        trap_ack = 1'b0;
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_ovf_count", 32'(ovf_count), 32'(mdl_cnt));
    endtask

    initial begin
        bit a;
        RST = 1'b1; in_valid = 1'b0; in_rdat1 = '0; in_rdat2 = '0; in_instr = '0;
        in_aluop = ALU_SLL; in_alusrc = 1'b0; out_ready = 1'b0;
        flush = 1'b0; trap_en = 1'b0; trap_ack = 1'b0;

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_alu_rdat1", alu_rdat1, 32'd0);

        // Single add, two-cycle latency.
        out_ready = 1'b1;
        drive(ALU_ADD, 32'd5, 32'd7);
        tick(a);
        chk("add_accept", 32'(a), 32'd1);
        in_valid = 1'b0;
        chk("add_not_yet", 32'(out_valid), 32'd0);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", out_result, 32'd12);
        step();
        step();

        // Back-to-back ops against a stalled consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(ALU_ADD, 32'(100 * (i + 1)), 32'(i + 1));
            tick(a);
            chk("b2b_accept", 32'(a), 32'd1);
        end
        drive(ALU_ADD, 32'd300, 32'd3);
        #1;
        chk("b2b_stall", 32'(in_ready), 32'd0);
        step();
        step();
        chk("b2b_stall_hold", 32'(in_ready), 32'd0);
        chk("b2b_head", out_result, 32'd101);
        out_ready = 1'b1;
        wait_accept("b2b_accept3");
        drive(ALU_ADD, 32'd400, 32'd4);
        wait_accept("b2b_accept4");
        in_valid = 1'b0;
        repeat (5) step();
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Overflow with trap enabled parks the stage until trap_ack.
        do_reset();
        trap_en   = 1'b1;
        out_ready = 1'b1;
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        tick(a);
        chk("trap_accept", 32'(a), 32'd1);
        drive(ALU_ADD, 32'd3, 32'd4);
        step();
        chk("trap_out_over", 32'(out_over), 32'd1);
        chk("trap_out_trap", 32'(out_trap), 32'd1);
        chk("trap_ovf_count", 32'(ovf_count), 32'd1);
        chk("trap_in_ready", 32'(in_ready), 32'd0);
        drive(ALU_ADD, 32'd9, 32'd9);
        repeat (3) step();
        chk("trap_hold_ready", 32'(in_ready), 32'd0);
        chk("trap_hold_s1", alu_rdat1, 32'd3);
        chk("trap_s2_drained", 32'(out_valid), 32'd0);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        chk("trap_release", 32'(in_ready), 32'd1);
        wait_accept("trap_post_accept");
        in_valid = 1'b0;
        repeat (4) step();

        // Same overflow without trap_en: counts but does not park.
        trap_en = 1'b0;
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        tick(a);
        chk("notrap_accept", 32'(a), 32'd1);
        in_valid = 1'b0;
        step();
        chk("notrap_over", 32'(out_over), 32'd1);
        chk("notrap_trap", 32'(out_trap), 32'd0);
        chk("notrap_in_ready", 32'(in_ready), 32'd1);
        chk("notrap_ovf_count", 32'(ovf_count), 32'd2);
        repeat (3) step();

        // Flush with both stages full and a new op on the input.
        do_reset();
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd2);
        tick(a);
        chk("flush_fill1", 32'(a), 32'd1);
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd5);
        tick(a);
        chk("flush_fill2", 32'(a), 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(ALU_ADD, 32'd4, 32'd4);
        tick(a);
        chk("flush_drop_input", 32'(a), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (5) step();
        chk("flush_ovf_count", 32'(ovf_count), 32'd0);
        chk("flush_quiet", 32'(out_valid), 32'd0);

        // Counter saturation, then reset in mid-stream.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ALU_ADD, 32'h7FFF_FFFF, 32'(i + 1));
            tick(a);
            chk("sat_accept", 32'(a), 32'd1);
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("sat_ovf_count", 32'(ovf_count), 32'd3);
        chk("sat_model", 32'(ovf_count), 32'(mdl_cnt));
        drive(ALU_ADD, 32'd10, 32'd20);
        step();
        out_ready = 1'b0;
        drive(ALU_SUB, 32'd50, 32'd8);
        step();
        RST = 1'b1;
        drive(ALU_OR, 32'd1, 32'd2);
        step();
        RST      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_result", out_result, 32'd0);
        chk("mrst_out_instr", out_instr, 32'd0);
        chk("mrst_out_over", 32'(out_over), 32'd0);
        chk("mrst_out_trap", 32'(out_trap), 32'd0);
        chk("mrst_alu_rdat1", alu_rdat1, 32'd0);
        chk("mrst_alu_instr", alu_instr, 32'd0);
        chk("mrst_ovf_count", 32'(ovf_count), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (4) step();

        // Randomized traffic, without and with traps.
        do_reset();
        rand_phase(400, 1'b0);
        do_reset();
        rand_phase(400, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
